alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage fed directly by the ALU-control decoder: takes the 3-bit alu_ctr
//  code plus two register operands, computes the result and flags, and delivers
//  them downstream to write-back.
//  Decouples the decoder from write-back with a valid/ready handshake on both sides.
//  A 2-entry output buffer absorbs write-back stalls without dropping operations.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      upstream presents alu_ctr/src_a/src_b this cycle
//  in_ready    out  1      stage can accept an operation this cycle
//  alu_ctr     in   3      operation code from the ALU-control decoder
//  src_a       in   WIDTH  operand A (rs)
//  src_b       in   WIDTH  operand B (rt)
//  out_valid   out  1      result/flags at buffer head are valid
//  out_ready   in   1      downstream consumes the head entry this cycle
//  result      out  WIDTH  result of the head entry
//  zero        out  1      head result == 0
//  overflow    out  1      signed overflow of head entry (ADD/SUB only)
//  illegal_op  out  1      head entry carried an unused alu_ctr code
// BEHAVIOUR
//  Clock and reset
//   - Single clock domain. rst_n is asynchronous, active-low.
//  Operation encoding (alu_ctr)
//   - 000 AND. 001 OR. 101 ADD. 110 SUB (A-B).
//   - 100 SLT: signed A<B; result = {WIDTH-1 zeros, lt}. Compare is true signed;
//     it does not use the subtraction sign bit alone.
//   - 111 MOVE: result = src_a.
//   - 010, 011 illegal: result = 0, illegal_op = 1, overflow = 0.
//  Arithmetic and flags
//   - ADD/SUB wrap modulo 2^WIDTH.
//   - overflow = operand signs agree (ADD) / differ (SUB) and result sign differs
//     from A. overflow is 0 for all other ops.
//   - zero = (result == 0). zero is computed for every op, including illegal.
//  Accept and latency
//   - An op is accepted on a rising edge with in_valid && in_ready.
//   - Result/flags are computed combinationally from the inputs and written into
//     the buffer at that edge.
//   - Latency: an op accepted at edge N with the buffer empty gives out_valid=1
//     after edge N, with its values on the outputs.
//  Output buffer: 2-entry FIFO, count in {0,1,2}
//   - in_ready = (count != 2), registered-count based. No combinational path from
//     out_ready to in_ready, so there is no accept when full, even if the head is
//     popped in the same cycle.
//   - Pop on edge when out_valid && out_ready.
//   - Push+pop with count=1: count stays 1 and the new entry becomes head next cycle.
//   - Push+pop with count=0: impossible (out_valid=0), so push only.
//   - Order is strictly FIFO. Read and write pointers wrap 1->0.
//   - out_valid = (count != 0). Outputs show the head entry.
//   - When count=0, result=0 and zero/overflow/illegal_op are all 0.
//   - Holding rule: while out_valid && !out_ready, the head entry is held stable.
//  Reset values
//   - count=0, pointers=0, out_valid=0, in_ready=1.
//   - result=0, zero=0, overflow=0, illegal_op=0.
//   - Asserting rst_n mid-operation discards all buffered entries immediately.
//     No partial op is delivered after release.
//  Bad inputs
//   - X/undefined alu_ctr while in_valid=0 is ignored.
// TESTING
//  1. Stream: out_ready=1, in_valid every cycle, ADD 3+4, AND F0&3C, OR 1|2
//     -> 7, 0x30, 3 on consecutive cycles one cycle after each accept;
//     in_ready stays 1.
//  2. ADD 0x7FFFFFFF+0x1 -> result 0x80000000, overflow=1, zero=0.
//     SUB 0x80000000-0x1 -> 0x7FFFFFFF, overflow=1.
//  3. SUB 5-5 -> result 0, zero=1.
//     SLT 0xFFFFFFFF vs 0x1 -> 1.
//     SLT 0x1 vs 0xFFFFFFFF -> 0.
//     MOVE A=0xDEADBEEF -> 0xDEADBEEF.
//  4. Backpressure: out_ready=0, offer MOVE 0xA, 0xB, 0xC back-to-back
//     -> 0xA and 0xB accepted, in_ready=0 while 0xC is held upstream.
//     Raise out_ready -> 0xA, 0xB, 0xC delivered in order; head stable while stalled.
//  5. alu_ctr=010 with A=5, B=5 -> result 0, illegal_op=1, zero=1, overflow=0.
//     Same for alu_ctr=011.
//  6. Fill 2 entries, pulse rst_n low between edges -> out_valid=0 and in_ready=1
//     asynchronously; no stale entry is seen after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes result/flags for one decoded op per accept and
// queues them in a 2-entry FIFO so write-back stalls never drop operations.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
        logic             ill;
    } entry_t;

    localparam entry_t ENTRY_CLEAR = '{res: '0, zero: 1'b0, ovf: 1'b0, ill: 1'b0};

    entry_t           mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    entry_t           alu_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             push_s;
    logic             pop_s;

    // Combinational ALU and flag generation for the offered op
    always_comb begin
        sum_s     = src_a + src_b;
        diff_s    = src_a - src_b;
        alu_s     = ENTRY_CLEAR;
        case (alu_ctr)
            3'b000: alu_s.res = src_a & src_b;
            3'b001: alu_s.res = src_a | src_b;
            3'b101: begin
                alu_s.res = sum_s;
                alu_s.ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b110: begin
                alu_s.res = diff_s;
                alu_s.ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            // True signed compare, immune to subtraction overflow
            3'b100: alu_s.res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b111: alu_s.res = src_a;
            default: begin
                alu_s.res = '0;
                alu_s.ill = 1'b1;
            end
        endcase
        alu_s.zero = (alu_s.res == '0);
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= ENTRY_CLEAR;
            mem_q[1] <= ENTRY_CLEAR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= alu_s;
            end
        end
    end

    // Head entry presentation; an empty buffer shows all zeros
    always_comb begin
        if (out_valid) begin
            result     = mem_q[rd_ptr_q].res;
            zero       = mem_q[rd_ptr_q].zero;
            overflow   = mem_q[rd_ptr_q].ovf;
            illegal_op = mem_q[rd_ptr_q].ill;
        end else begin
            result     = '0;
            zero       = 1'b0;
            overflow   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
